// File: rtl/serial_sub8.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Optional signed-overflow flag on output ovf when SERIAL_SUB_OVF_EN is defined.
module serial_sub8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic             w_accept;

  // One full-subtractor cell operating on the current LSBs
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_accept  = (r_state == StIdle) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_next = StRun;
      end
      StRun: begin
        busy = 1'b1;
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;

  // Operand MSBs are shifted out during RUN, so keep copies for the overflow test
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (r_state == StRun && w_last) begin
      ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == StRun) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_br_next;
      r_res <= {w_d, r_res[WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        diff <= {w_d, r_res[WIDTH-1:1]};
        bout <= w_br_next;
      end
    end
  end

endmodule
